// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, parity mode constants,
// and the oversample clock divider calculation used by both RX and TX paths.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BREAK_WAIT
    } rx_state_t;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    // Rounded clk_freq / (baud * os).
    function automatic int calc_div(input int clk_freq, input int baud, input int os);
        return (clk_freq + (baud * os) / 2) / (baud * os);
    endfunction

endpackage

// File: rtl/uart_os_tick.sv
// Oversample tick generator: counts 0..DIV-1 and pulses os_tick_o on DIV-1.
// Held at zero while clear_i is high so the first tick after a start edge
// always lands a fixed number of clocks later.
// Ports:
//   clk, rst_n  clock, async active-low reset
//   clear_i     synchronous counter clear (also masks the tick)
//   os_tick_o   one-cycle pulse per oversample period
module uart_os_tick #(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    output logic os_tick_o
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i || cnt_q == LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    assign os_tick_o = !clear_i && (cnt_q == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: synchronizes rxd, oversamples each bit with a 3-sample
// majority vote around mid-bit, rebuilds 8-bit LSB-first frames with optional
// parity, and presents bytes on a valid/ready port with per-frame error flags.
// Ports:
//   clk, rst_n     clock, async active-low reset
//   uart_en_i      receiver enable; low forces IDLE and drops any partial frame
//   rxd_i          asynchronous serial input, idle high
//   rx_data_o      received byte, stable while rx_valid_o
//   rx_valid_o     byte available, held until rx_ready_i
//   rx_ready_i     consumer accept
//   frame_err_o    stop bit sampled low (qualified by rx_valid_o)
//   parity_err_o   parity mismatch (qualified by rx_valid_o)
//   overrun_o      one-cycle pulse: finished frame dropped, previous byte unread
//   busy_o         FSM not in IDLE
//
// state         | meaning
// ST_IDLE       | waiting for a falling edge on the synced line
// ST_START      | validating start bit; high majority at mid-bit = glitch
// ST_DATA       | shifting in 8 data bits, LSB first
// ST_PARITY     | sampling parity bit and computing mismatch
// ST_STOP       | sampling stop bit; delivers the frame at mid-bit
// ST_BREAK_WAIT | stop bit was low; wait for line to return high
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD_RATE  = 115200,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY     = PARITY_NONE
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       uart_en_i,
    input  logic       rxd_i,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    input  logic       rx_ready_i,
    output logic       frame_err_o,
    output logic       parity_err_o,
    output logic       overrun_o,
    output logic       busy_o
);

    localparam int DIV = calc_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
    localparam int SW  = $clog2(OVERSAMPLE);
    localparam logic [SW-1:0] SUB_MM1  = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] SUB_M    = SW'(OVERSAMPLE / 2);
    localparam logic [SW-1:0] SUB_MP1  = SW'(OVERSAMPLE / 2 + 1);
    localparam logic [SW-1:0] SUB_LAST = SW'(OVERSAMPLE - 1);

    if (DIV < 1) begin : g_div_chk
        $error("uart_rx: CLK_FREQ too low for BAUD_RATE*OVERSAMPLE");
    end
    if (OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0) begin : g_os_chk
        $error("uart_rx: OVERSAMPLE must be even and >= 8");
    end

    logic            rxd_meta_q, rxs_q, rxs_prev_q;
    rx_state_t       state_q, state_d;
    logic [SW-1:0]   sub_q, sub_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic [1:0]      samp_q, samp_d;
    logic            par_bad_q, par_bad_d;
    logic [7:0]      rx_data_q, rx_data_d;
    logic            rx_valid_q, rx_valid_d;
    logic            frame_err_q, frame_err_d;
    logic            parity_err_q, parity_err_d;
    logic            overrun_q, overrun_d;

    logic            os_tick, maj, at_mid, bit_end, frame_done;

    uart_os_tick #(
        .DIV (DIV)
    ) u_os_tick (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear_i   (state_q == ST_IDLE),
        .os_tick_o (os_tick)
    );

    // Majority of the two stored samples and the live sample at sub-tick M+1.
    assign maj     = (samp_q[0] & samp_q[1]) | (samp_q[0] & rxs_q) | (samp_q[1] & rxs_q);
    assign at_mid  = os_tick && (sub_q == SUB_MP1);
    assign bit_end = os_tick && (sub_q == SUB_LAST);

    always_comb begin
        state_d      = state_q;
        sub_d        = sub_q;
        bit_d        = bit_q;
        shift_d      = shift_q;
        samp_d       = samp_q;
        par_bad_d    = par_bad_q;
        rx_data_d    = rx_data_q;
        rx_valid_d   = rx_valid_q;
        frame_err_d  = frame_err_q;
        parity_err_d = parity_err_q;
        overrun_d    = 1'b0;
        frame_done   = 1'b0;

        if (state_q == ST_IDLE) begin
            sub_d = '0;
        end else if (os_tick) begin
            sub_d = (sub_q == SUB_LAST) ? '0 : sub_q + SW'(1);
        end

        if (os_tick && sub_q == SUB_MM1) samp_d[0] = rxs_q;
        if (os_tick && sub_q == SUB_M)   samp_d[1] = rxs_q;

        if (rx_valid_q && rx_ready_i) rx_valid_d = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                bit_d     = '0;
                par_bad_d = 1'b0;
                if (uart_en_i && rxs_prev_q && !rxs_q) state_d = ST_START;
            end
            ST_START: begin
                if (at_mid && maj) begin
                    state_d = ST_IDLE;
                end else if (bit_end) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (at_mid) shift_d = {maj, shift_q[7:1]};
                if (bit_end) begin
                    if (bit_q == 3'd7) begin
                        state_d = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            ST_PARITY: begin
                if (at_mid) par_bad_d = ((^shift_q) ^ maj) != (PARITY == PARITY_ODD);
                if (bit_end) state_d = ST_STOP;
            end
            ST_STOP: begin
                // Finish at mid stop bit so a back-to-back start edge is not missed.
                if (at_mid) begin
                    frame_done = uart_en_i;
                    state_d    = maj ? ST_IDLE : ST_BREAK_WAIT;
                end
            end
            ST_BREAK_WAIT: begin
                if (rxs_q) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (frame_done) begin
            if (!rx_valid_q || rx_ready_i) begin
                rx_data_d    = shift_q;
                frame_err_d  = !maj;
                parity_err_d = par_bad_q;
                rx_valid_d   = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end

        if (!uart_en_i) state_d = ST_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxd_meta_q   <= 1'b1;
            rxs_q        <= 1'b1;
            rxs_prev_q   <= 1'b1;
            state_q      <= ST_IDLE;
            sub_q        <= '0;
            bit_q        <= '0;
            shift_q      <= '0;
            samp_q       <= '0;
            par_bad_q    <= 1'b0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            rxd_meta_q   <= rxd_i;
            rxs_q        <= rxd_meta_q;
            rxs_prev_q   <= rxs_q;
            state_q      <= state_d;
            sub_q        <= sub_d;
            bit_q        <= bit_d;
            shift_q      <= shift_d;
            samp_q       <= samp_d;
            par_bad_q    <= par_bad_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
            overrun_q    <= overrun_d;
        end
    end

    assign rx_data_o    = rx_data_q;
    assign rx_valid_o   = rx_valid_q;
    assign frame_err_o  = frame_err_q;
    assign parity_err_o = parity_err_q;
    assign overrun_o    = overrun_q;
    assign busy_o       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: one 8N1 instance and one 8E1 instance, 32 clk per bit.
module tb_uart_rx;

    localparam int CF  = 3_200_000;
    localparam int BR  = 100_000;
    localparam int OS  = 16;
    localparam int BIT = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, en;
    logic       rxd_n, rxd_p, ready_n, ready_p;
    logic [7:0] n_data, p_data;
    logic       n_valid, n_fe, n_pe, n_ovr, n_busy;
    logic       p_valid, p_fe, p_pe, p_ovr, p_busy;

    uart_rx #(.CLK_FREQ(CF), .BAUD_RATE(BR), .OVERSAMPLE(OS), .PARITY(0)) dut_n (
        .clk(clk), .rst_n(rst_n), .uart_en_i(en), .rxd_i(rxd_n),
        .rx_data_o(n_data), .rx_valid_o(n_valid), .rx_ready_i(ready_n),
        .frame_err_o(n_fe), .parity_err_o(n_pe), .overrun_o(n_ovr), .busy_o(n_busy)
    );

    uart_rx #(.CLK_FREQ(CF), .BAUD_RATE(BR), .OVERSAMPLE(OS), .PARITY(2)) dut_p (
        .clk(clk), .rst_n(rst_n), .uart_en_i(en), .rxd_i(rxd_p),
        .rx_data_o(p_data), .rx_valid_o(p_valid), .rx_ready_i(ready_p),
        .frame_err_o(p_fe), .parity_err_o(p_pe), .overrun_o(p_ovr), .busy_o(p_busy)
    );

    typedef struct {
        logic [7:0] d;
        logic       fe;
        logic       pe;
        int         t;
    } cap_t;

    typedef struct {
        bit         sel;
        logic [7:0] data;
        logic       pbit;
        logic       sbit;
        logic [7:0] exp_data;
        logic       exp_fe;
        logic       exp_pe;
    } vec_t;

    cap_t q_n[$];
    cap_t q_p[$];
    int   ovr_cnt_n = 0, ovr_cnt_p = 0;
    int   cyc = 0;
    int   t_start = 0;
    int   checks = 0, passed = 0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (n_valid && ready_n) q_n.push_back('{n_data, n_fe, n_pe, cyc});
        if (p_valid && ready_p) q_p.push_back('{p_data, p_fe, p_pe, cyc});
        if (n_ovr) ovr_cnt_n++;
        if (p_ovr) ovr_cnt_p++;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit sel, input logic v);
        if (sel) rxd_p = v;
        else     rxd_n = v;
    endtask

    // Leaves the line at the stop-bit level; caller releases it.
    task automatic send_frame(input bit sel, input logic [7:0] d, input logic pbit, input logic sbit);
        t_start = cyc;
        drive(sel, 1'b0);
        wait_clk(BIT);
        for (int i = 0; i < 8; i++) begin
            drive(sel, d[i]);
            wait_clk(BIT);
        end
        if (sel) begin
            drive(sel, pbit);
            wait_clk(BIT);
        end
        drive(sel, sbit);
        wait_clk(BIT);
    endtask

    task automatic check_cap(input bit sel, input string nm, input logic [7:0] ed,
                             input logic efe, input logic epe);
        cap_t c;
        int   n;
        c = '{8'h00, 1'b0, 1'b0, 0};
        n = sel ? q_p.size() : q_n.size();
        if (n > 0) c = sel ? q_p[0] : q_n[0];
        check({nm, " count"}, n, 1);
        check({nm, " data"}, c.d, ed);
        check({nm, " frame_err"}, c.fe, efe);
        check({nm, " parity_err"}, c.pe, epe);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t vecs[9];
        int   lat;

        vecs[0] = '{1'b0, 8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 8'hFF, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 8'h6B, 1'b0, 1'b0, 8'h6B, 1'b1, 1'b0};
        vecs[4] = '{1'b1, 8'h37, 1'b0, 1'b1, 8'h37, 1'b0, 1'b1};
        vecs[5] = '{1'b1, 8'h37, 1'b1, 1'b1, 8'h37, 1'b0, 1'b0};
        vecs[6] = '{1'b1, 8'h00, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1};
        vecs[7] = '{1'b1, 8'h80, 1'b1, 1'b1, 8'h80, 1'b0, 1'b0};
        vecs[8] = '{1'b1, 8'h80, 1'b1, 1'b0, 8'h80, 1'b1, 1'b0};

        rst_n = 1'b0; en = 1'b1; rxd_n = 1'b1; rxd_p = 1'b1;
        ready_n = 1'b1; ready_p = 1'b1;
        wait_clk(3);
        check("reset rx_data", n_data, 8'h00);
        check("reset flags", {n_valid, n_fe, n_pe, n_ovr, n_busy}, 5'b0);
        check("reset flags parity inst", {p_valid, p_fe, p_pe, p_ovr, p_busy}, 5'b0);
        rst_n = 1'b1;
        wait_clk(5);

        // Table-driven frames.
        for (int i = 0; i < 9; i++) begin
            q_n.delete();
            q_p.delete();
            send_frame(vecs[i].sel, vecs[i].data, vecs[i].pbit, vecs[i].sbit);
            drive(vecs[i].sel, 1'b1);
            wait_clk(BIT);
            check_cap(vecs[i].sel, $sformatf("vec%0d", i), vecs[i].exp_data,
                      vecs[i].exp_fe, vecs[i].exp_pe);
            if (i == 0) begin
                lat = (q_n.size() > 0) ? q_n[0].t - t_start : 0;
                check("latency in window", (lat >= 300 && lat <= 320), 1);
                check("valid dropped after accept", n_valid, 1'b0);
            end
        end

        // Stop bit low, line held low: flagged frame, then no new start until high.
        q_n.delete();
        send_frame(1'b0, 8'h55, 1'b0, 1'b0);
        wait_clk(100);
        check_cap(1'b0, "break", 8'h55, 1'b1, 1'b0);
        check("break busy while low", n_busy, 1'b1);
        drive(1'b0, 1'b1);
        wait_clk(5);
        check("break busy after release", n_busy, 1'b0);
        q_n.delete();
        send_frame(1'b0, 8'h3C, 1'b0, 1'b1);
        wait_clk(BIT);
        check_cap(1'b0, "after break", 8'h3C, 1'b0, 1'b0);

        // Overrun, retention across uart_en low, and deliver coinciding with accept.
        q_n.delete();
        ready_n = 1'b0;
        ovr_cnt_n = 0;
        send_frame(1'b0, 8'h11, 1'b0, 1'b1);
        wait_clk(BIT);
        check("ovr first valid", n_valid, 1'b1);
        send_frame(1'b0, 8'h22, 1'b0, 1'b1);
        wait_clk(BIT);
        check("overrun pulse count", ovr_cnt_n, 1);
        check("overrun data kept", n_data, 8'h11);
        check("overrun valid kept", n_valid, 1'b1);
        en = 1'b0;
        wait_clk(5);
        check("valid kept with en low", {n_valid, n_data}, {1'b1, 8'h11});
        en = 1'b1;
        wait_clk(5);
        ovr_cnt_n = 0;
        fork
            send_frame(1'b0, 8'h33, 1'b0, 1'b1);
            begin
                wait_clk(310);
                ready_n = 1'b1;
                wait_clk(1);
                ready_n = 1'b0;
            end
        join
        wait_clk(BIT);
        check_cap(1'b0, "accept at deliver", 8'h11, 1'b0, 1'b0);
        check("no overrun at accept", ovr_cnt_n, 0);
        check("new byte loaded", {n_valid, n_data}, {1'b1, 8'h33});
        q_n.delete();
        ready_n = 1'b1;
        wait_clk(2);
        check_cap(1'b0, "drain", 8'h33, 1'b0, 1'b0);
        check("drain valid low", n_valid, 1'b0);

        // Short low glitch on an idle line.
        q_n.delete();
        drive(1'b0, 1'b0);
        wait_clk(4);
        check("glitch busy", n_busy, 1'b1);
        wait_clk(2);
        drive(1'b0, 1'b1);
        wait_clk(60);
        check("glitch back idle", n_busy, 1'b0);
        check("glitch no frame", q_n.size() + n_valid, 0);

        // uart_en dropped at data bit 4 of 0xF0.
        q_n.delete();
        fork
            send_frame(1'b0, 8'hF0, 1'b0, 1'b1);
            begin
                wait_clk(170);
                en = 1'b0;
                wait_clk(2);
                check("en low busy", n_busy, 1'b0);
                wait_clk(20);
                en = 1'b1;
            end
        join
        wait_clk(BIT);
        check("en drop no frame", q_n.size() + n_valid + n_busy, 0);

        // Re-enable on a line already low: no start without a fresh fall.
        en = 1'b0;
        wait_clk(2);
        drive(1'b0, 1'b0);
        wait_clk(10);
        en = 1'b1;
        wait_clk(40);
        check("reenable low line idle", n_busy, 1'b0);
        drive(1'b0, 1'b1);
        wait_clk(40);

        // Reset mid-frame.
        fork
            send_frame(1'b0, 8'hF0, 1'b0, 1'b1);
            begin
                wait_clk(100);
                rst_n = 1'b0;
                wait_clk(2);
                check("reset mid-frame", {n_busy, n_valid}, 2'b00);
                wait_clk(250);
                rst_n = 1'b1;
            end
        join
        wait_clk(BIT);
        check("reset no frame", q_n.size() + n_valid, 0);
        q_n.delete();
        send_frame(1'b0, 8'h3C, 1'b0, 1'b1);
        wait_clk(BIT);
        check_cap(1'b0, "after reset", 8'h3C, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
